user_core_nmi_bridge: RTL and testbench

USER_CORE_NMI_BRIDGE -- requirements
Module: user_core_nmi_bridge

---
 rtl/user_core_nmi_bridge_if.sv | 12 +
 rtl/user_core_nmi_bridge.sv | 176 +++++++++++++++++
 tb/tb_user_core_nmi_bridge.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/user_core_nmi_bridge_if.sv
// rtl/user_core_nmi_bridge_if.sv - NMI bus interface between user core bridge and fabric
interface nmi_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/user_core_nmi_bridge.sv
// rtl/user_core_nmi_bridge.sv - user core to NMI bridge with posted-write buffer and read ordering
module user_core_nmi_bridge #(
  parameter logic [4:0]  ID          = 5'd31,
  parameter int          WBUF_DEPTH  = 4,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF,
  parameter logic [31:0] IRQ_MASK    = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [3:0]  core_wmask_i,
  input  logic        core_rstrb_i,
  output logic [31:0] core_rdata_o,
  output logic        core_rbusy_o,
  output logic        core_wbusy_o,
  input  logic [31:0] irq_i,
  output logic        core_irq_o,
  output logic        err_o,
  nmi_if.master       nmi
);

  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW = $clog2(WBUF_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(WBUF_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WBUF_DEPTH);
  localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } wentry_t;

  // slot id is informational only
  logic unused_id;
  assign unused_id = ^ID;

  wentry_t       mem_q [WBUF_DEPTH];
  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   tmo_q, tmo_d;
  logic          rd_pend_q, rd_pend_d;
  logic [31:0]   rd_addr_q, rd_addr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          wbusy_q, wbusy_d;
  logic          irq_q, irq_d;
  logic          err_q, err_d;
  logic          push, pop, full, tmo_hit;
  wentry_t       head;

  assign full    = (count_q == CNT_FULL);
  assign head    = mem_q[rd_ptr_q];
  assign tmo_hit = !nmi.ready && (tmo_q == TMO_LAST);

  // bus outputs come straight from registered state so they hold steady while valid
  assign nmi.valid = (state_q == WR) || (state_q == RD);
  assign nmi.addr  = (state_q == WR) ? head.addr  : (state_q == RD) ? rd_addr_q : 32'h0;
  assign nmi.wdata = (state_q == WR) ? head.wdata : 32'h0;
  assign nmi.wstrb = (state_q == WR) ? head.wmask : 4'h0;

  assign core_rdata_o = rdata_q;
  assign core_rbusy_o = rd_pend_q;
  assign core_wbusy_o = wbusy_q;
  assign core_irq_o   = irq_q;
  assign err_o        = err_q;

  // next-state: write buffer, read capture, transaction FSM, timeout and error tracking
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tmo_d     = '0;
    rd_pend_d = rd_pend_q;
    rd_addr_d = rd_addr_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    pop       = 1'b0;
    push      = (core_wmask_i != 4'h0) && !full;

    if ((core_wmask_i != 4'h0) && full) err_d = 1'b1;

    if (core_rstrb_i) begin
      if (rd_pend_q) begin
        err_d = 1'b1;
      end else begin
        rd_pend_d = 1'b1;
        rd_addr_d = core_addr_i;
      end
    end

    case (state_q)
      IDLE: begin
        // buffered writes always drain before a read goes out
        if (count_q != '0) state_d = WR;
        else if (rd_pend_q) state_d = RD;
      end
      WR: begin
        if (nmi.ready || tmo_hit) begin
          pop     = 1'b1;
          state_d = IDLE;
          if (tmo_hit) err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      RD: begin
        if (nmi.ready) begin
          rdata_d   = nmi.rdata;
          rd_pend_d = 1'b0;
          state_d   = DONE;
        end else if (tmo_hit) begin
          rdata_d   = ERR_DATA;
          rd_pend_d = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    wbusy_d = (count_d == CNT_FULL);
    irq_d   = |(irq_i & IRQ_MASK);
  end

  // control and status registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tmo_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      rdata_q   <= '0;
      wbusy_q   <= 1'b0;
      irq_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tmo_q     <= tmo_d;
      rd_pend_q <= rd_pend_d;
      rd_addr_q <= rd_addr_d;
      rdata_q   <= rdata_d;
      wbusy_q   <= wbusy_d;
      irq_q     <= irq_d;
      err_q     <= err_d;
    end
  end

  // buffer storage; contents are don't-care while the count says empty
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: core_addr_i, wdata: core_wdata_i, wmask: core_wmask_i};
  end

endmodule

// File: tb/tb_user_core_nmi_bridge.sv
// tb/tb_user_core_nmi_bridge.sv - directed self-checking bench for user_core_nmi_bridge
module tb_user_core_nmi_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic [3:0]  core_wmask = '0;
  logic        core_rstrb = 1'b0;
  logic [31:0] core_rdata;
  logic        core_rbusy;
  logic        core_wbusy;
  logic [31:0] irq = '0;
  logic        core_irq;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int stab_err = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          cyc;
  } beat_t;

  beat_t beats[$];
  logic  prev_v = 1'b0;
  logic  prev_r = 1'b0;
  logic [67:0] prev_f = '0;

  nmi_if nmi ();

  user_core_nmi_bridge #(
    .ID(5'd3), .WBUF_DEPTH(4), .TIMEOUT_CYC(8),
    .ERR_DATA(32'hDEAD_BEEF), .IRQ_MASK(32'hFFFF_FFEF)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_wmask_i(core_wmask),
    .core_rstrb_i(core_rstrb), .core_rdata_o(core_rdata), .core_rbusy_o(core_rbusy),
    .core_wbusy_o(core_wbusy), .irq_i(irq), .core_irq_o(core_irq), .err_o(err),
    .nmi(nmi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record every handshake and watch that request fields hold while stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v <= 1'b0;
    end else begin
      if (nmi.valid && nmi.ready)
        beats.push_back('{addr: nmi.addr, wdata: nmi.wdata, wstrb: nmi.wstrb, cyc: cyc});
      if (prev_v && !prev_r && nmi.valid && ({nmi.addr, nmi.wdata, nmi.wstrb} != prev_f))
        stab_err <= stab_err + 1;
      prev_v <= nmi.valid;
      prev_r <= nmi.ready;
      prev_f <= {nmi.addr, nmi.wdata, nmi.wstrb};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t get_beat(input int i);
    beat_t b;
    b = '0;
    if (i < beats.size()) b = beats[i];
    return b;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    core_wmask = '0;
    core_rstrb = 1'b0;
    nmi.ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    beats.delete();
    tick();
  endtask

  task automatic wait_valid(input string tag);
    int k;
    for (k = 0; k < 20 && !nmi.valid; k++) tick();
    if (!nmi.valid) chk(tag, 32'(nmi.valid), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int nvalid;
    int low_cyc;
    beat_t b;

    nmi.ready = 1'b0;
    nmi.rdata = 32'hCAFE_F00D;
    tick();
    tick();
    chk("rst_valid", 32'(nmi.valid), 32'h0);
    chk("rst_rbusy", 32'(core_rbusy), 32'h0);
    chk("rst_wbusy", 32'(core_wbusy), 32'h0);
    chk("rst_rdata", core_rdata, 32'h0);
    chk("rst_irq", 32'(core_irq), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    do_reset();

    // single write, ready on second valid cycle
    core_addr = 32'h1000_0000; core_wdata = 32'h1234_5678; core_wmask = 4'hF;
    tick();
    core_wmask = 4'h0;
    wait_valid("w1_valid");
    tick();
    nmi.ready = 1'b1;
    tick();
    nmi.ready = 1'b0;
    b = get_beat(0);
    chk("w1_beats", 32'(beats.size()), 32'd1);
    chk("w1_addr", b.addr, 32'h1000_0000);
    chk("w1_wdata", b.wdata, 32'h1234_5678);
    chk("w1_wstrb", 32'(b.wstrb), 32'hF);
    chk("w1_valid_low", 32'(nmi.valid), 32'h0);
    chk("w1_err", 32'(err), 32'h0);
    repeat (5) tick();
    chk("w1_no_extra", 32'(beats.size()), 32'd1);

    // five writes into a depth-4 buffer with ready low
    do_reset();
    for (int i = 0; i < 5; i++) begin
      core_addr = 32'h100 + 32'(i * 4); core_wdata = 32'hA0 + 32'(i); core_wmask = 4'hF;
      tick();
      if (i == 3) chk("ff_wbusy_4th", 32'(core_wbusy), 32'h1);
      if (i == 2) chk("ff_wbusy_3rd", 32'(core_wbusy), 32'h0);
    end
    core_wmask = 4'h0;
    chk("ff_err", 32'(err), 32'h1);
    chk("ff_no_beats", 32'(beats.size()), 32'd0);
    nmi.ready = 1'b1;
    for (k = 0; k < 30 && beats.size() < 4; k++) tick();
    repeat (4) tick();
    chk("ff_beats", 32'(beats.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      b = get_beat(i);
      chk($sformatf("ff_addr%0d", i), b.addr, 32'h100 + 32'(i * 4));
      chk($sformatf("ff_wdata%0d", i), b.wdata, 32'hA0 + 32'(i));
    end
    chk("ff_wbusy_end", 32'(core_wbusy), 32'h0);
    nmi.ready = 1'b0;

    // read after two writes, zero-wait ready
    do_reset();
    nmi.ready = 1'b1;
    core_addr = 32'h300; core_wdata = 32'h11; core_wmask = 4'h3; tick();
    core_addr = 32'h304; core_wdata = 32'h22; core_wmask = 4'hC; tick();
    core_wmask = 4'h0;
    core_addr = 32'h2000_0000; core_rstrb = 1'b1; tick();
    core_rstrb = 1'b0;
    chk("raw_rbusy", 32'(core_rbusy), 32'h1);
    low_cyc = -1;
    for (k = 0; k < 30; k++) begin
      if (!core_rbusy) begin low_cyc = cyc; break; end
      tick();
    end
    chk("raw_beats", 32'(beats.size()), 32'd3);
    b = get_beat(0);
    chk("raw_b0_addr", b.addr, 32'h300);
    chk("raw_b0_wstrb", 32'(b.wstrb), 32'h3);
    b = get_beat(1);
    chk("raw_b1_addr", b.addr, 32'h304);
    chk("raw_b1_wstrb", 32'(b.wstrb), 32'hC);
    b = get_beat(2);
    chk("raw_rd_addr", b.addr, 32'h2000_0000);
    chk("raw_rd_wstrb", 32'(b.wstrb), 32'h0);
    chk("raw_rbusy_lat", 32'(low_cyc), 32'(b.cyc + 1));
    chk("raw_rdata", core_rdata, 32'hCAFE_F00D);

    // minimum read latency with empty buffer
    nmi.rdata = 32'h1357_9BDF;
    core_addr = 32'h2000_0040; core_rstrb = 1'b1; tick();
    core_rstrb = 1'b0;
    chk("lat_rbusy1", 32'(core_rbusy), 32'h1);
    tick();
    chk("lat_rbusy2", 32'(core_rbusy), 32'h1);
    tick();
    chk("lat_rbusy3", 32'(core_rbusy), 32'h0);
    chk("lat_rdata", core_rdata, 32'h1357_9BDF);
    chk("lat_err", 32'(err), 32'h0);
    nmi.ready = 1'b0;

    // read timeout with ready never asserted
    do_reset();
    core_addr = 32'h2000_0080; core_rstrb = 1'b1; tick();
    core_rstrb = 1'b0;
    wait_valid("to_valid");
    nvalid = 0;
    for (k = 0; k < 40 && nmi.valid; k++) begin nvalid++; tick(); end
    chk("to_cycles", 32'(nvalid), 32'd8);
    chk("to_rdata", core_rdata, 32'hDEAD_BEEF);
    chk("to_err", 32'(err), 32'h1);
    chk("to_rbusy", 32'(core_rbusy), 32'h0);

    // second read strobe while one is pending
    do_reset();
    core_addr = 32'h2000_00C0; core_rstrb = 1'b1; tick();
    chk("dbl_err_first", 32'(err), 32'h0);
    tick();
    core_rstrb = 1'b0;
    chk("dbl_err", 32'(err), 32'h1);

    // interrupt masking
    do_reset();
    irq = 32'h0000_0010; tick(); tick();
    chk("irq_masked", 32'(core_irq), 32'h0);
    irq = 32'h0000_0001; tick();
    chk("irq_on", 32'(core_irq), 32'h1);
    irq = 32'h0; tick();
    chk("irq_off", 32'(core_irq), 32'h0);

    // reset while a write waits and three entries are buffered
    do_reset();
    for (int i = 0; i < 3; i++) begin
      core_addr = 32'h400 + 32'(i * 4); core_wdata = 32'(i); core_wmask = 4'hF; tick();
    end
    core_wmask = 4'h0;
    tick();
    chk("mid_valid", 32'(nmi.valid), 32'h1);
    beats.delete();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(nmi.valid), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    nmi.ready = 1'b1;
    repeat (10) tick();
    chk("mid_no_beats", 32'(beats.size()), 32'd0);
    chk("mid_wbusy", 32'(core_wbusy), 32'h0);
    nmi.ready = 1'b0;

    chk("stable_fields", 32'(stab_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
